// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the execute stage and a word-wide data memory.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two transactions.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [1:0]  off_reg;
  logic        split_reg;
  logic        err_reg;
  logic [63:0] wdata_reg;
  logic [7:0]  mask_reg;
  logic [31:0] rdata0_reg, rdata1_reg;
  logic [15:0] cnt_reg;

  logic [1:0]  in_off;
  logic [2:0]  in_size;
  logic [3:0]  in_base;
  logic        in_illegal, in_misal, in_cross, in_err, in_split;
  logic [63:0] in_wdata;
  logic [7:0]  in_mask;

  always_comb begin
    in_off = req_addr[1:0];
    case (req_funct3[1:0])
      2'b00:   begin in_size = 3'd1; in_base = 4'b0001; end
      2'b01:   begin in_size = 3'd2; in_base = 4'b0011; end
      default: begin in_size = 3'd4; in_base = 4'b1111; end
    endcase
    in_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    in_misal   = ((in_size == 3'd2) && in_off[0]) || ((in_size == 3'd4) && (in_off != 2'b00));
    in_cross   = (({1'b0, in_off} + in_size) > 3'd4);
`ifdef LSU_MISALIGNED_SPLIT_EN
    in_err   = in_illegal;
    in_split = in_cross && !in_illegal;
`else
    // Any misaligned access is rejected before it reaches memory.
    in_err   = in_illegal || in_misal;
    in_split = 1'b0;
`endif
    in_wdata = {32'b0, req_wdata} << {in_off, 3'b000};
    in_mask  = {4'b0000, in_base} << in_off;
  end

  logic tmo, tmo_fire;
  assign tmo = (cnt_reg == TMO_LAST);

  always_comb begin
    state_next = state_reg;
    tmo_fire   = 1'b0;
    case (state_reg)
      IDLE:  if (req_valid) state_next = in_err ? RESP : REQ0;
      REQ0: begin
        if (mem_gnt)  state_next = !we_reg ? WAIT0 : (split_reg ? REQ1 : RESP);
        else if (tmo) begin state_next = RESP; tmo_fire = 1'b1; end
      end
      WAIT0: begin
        if (mem_rvalid) state_next = split_reg ? REQ1 : RESP;
        else if (tmo)   begin state_next = RESP; tmo_fire = 1'b1; end
      end
      REQ1: begin
        if (mem_gnt)  state_next = we_reg ? RESP : WAIT1;
        else if (tmo) begin state_next = RESP; tmo_fire = 1'b1; end
      end
      WAIT1: begin
        if (mem_rvalid) state_next = RESP;
        else if (tmo)   begin state_next = RESP; tmo_fire = 1'b1; end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= 32'b0;
      off_reg    <= 2'b00;
      split_reg  <= 1'b0;
      err_reg    <= 1'b0;
      wdata_reg  <= 64'b0;
      mask_reg   <= 8'b0;
      rdata0_reg <= 32'b0;
      rdata1_reg <= 32'b0;
      cnt_reg    <= 16'b0;
    end else begin
      state_reg <= state_next;
      // Counter restarts on every state change, so each REQ/WAIT state gets a fresh budget.
      if (state_next != state_reg) cnt_reg <= 16'b0;
      else if (state_reg != IDLE && state_reg != RESP) cnt_reg <= cnt_reg + 16'd1;
      if (state_reg == IDLE && req_valid) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= {req_addr[31:2], 2'b00};
        off_reg    <= in_off;
        split_reg  <= in_split;
        err_reg    <= in_err;
        wdata_reg  <= in_wdata;
        mask_reg   <= in_mask;
        rdata0_reg <= 32'b0;
        rdata1_reg <= 32'b0;
      end
      if (tmo_fire) err_reg <= 1'b1;
      if (state_reg == WAIT0 && mem_rvalid) rdata0_reg <= mem_rdata;
      if (state_reg == WAIT1 && mem_rvalid) rdata1_reg <= mem_rdata;
    end
  end

  logic [63:0] load_shift;
  logic [31:0] load_word;

  always_comb begin
    load_shift = {rdata1_reg, rdata0_reg} >> {off_reg, 3'b000};
    load_word  = load_shift[31:0];
    req_ready  = (state_reg == IDLE);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'b0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'b0;
    if (state_reg == REQ0 || state_reg == REQ1) begin
      mem_req  = 1'b1;
      mem_we   = we_reg;
      mem_addr = (state_reg == REQ0) ? addr_reg : addr_reg + 32'd4;
      if (we_reg) begin
        mem_be    = (state_reg == REQ0) ? mask_reg[3:0] : mask_reg[7:4];
        mem_wdata = (state_reg == REQ0) ? wdata_reg[31:0] : wdata_reg[63:32];
      end else begin
        mem_be = 4'hF;
      end
    end
    if (state_reg == RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_reg;
      if (!err_reg && !we_reg) begin
        case (funct3_reg)
          3'b000:  rsp_rdata = {{24{load_word[7]}}, load_word[7:0]};
          3'b001:  rsp_rdata = {{16{load_word[15]}}, load_word[15:0]};
          3'b100:  rsp_rdata = {24'b0, load_word[7:0]};
          3'b101:  rsp_rdata = {16'b0, load_word[15:0]};
          default: rsp_rdata = load_word;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (timeout shortened to 4 cycles).
// Split-mode expectations follow LSU_MISALIGNED_SPLIT_EN when defined.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  int n_checks = 0;
  int n_pass = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; on return the DUT is in the cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word, input logic [31:0] exp_v);
    mem_gnt = 1'b1;
    issue(1'b0, f3, addr, 32'b0);
    chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".be"}, {28'b0, mem_be}, 32'hF);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
    chk({tag, ".wait_noreq"}, {31'b0, mem_req}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk({tag, ".rsp_valid_t3"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, exp_v);
    chk({tag, ".err"}, {31'b0, rsp_err}, 32'd0);
    tick();
    $display("load %s addr=%h rdata=%h", tag, addr, exp_v);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    mem_gnt = 1'b1;
    issue(1'b1, f3, addr, wdata);
    chk({tag, ".req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, ".we"}, {31'b0, mem_we}, 32'd1);
    chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".be"}, {28'b0, mem_be}, {28'b0, exp_be});
    chk({tag, ".wdata"}, mem_wdata, exp_wd);
    tick();
    mem_gnt = 1'b0;
    chk({tag, ".rsp_valid_t2"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".err"}, {31'b0, rsp_err}, 32'd0);
    chk({tag, ".rdata0"}, rsp_rdata, 32'd0);
    tick();
    $display("store %s addr=%h be=%h wdata=%h", tag, addr, exp_be, exp_wd);
  endtask

  // Expect an immediate error response with no memory access.
  task automatic run_reject(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
    issue(we, f3, addr, 32'hFFFF_FFFF);
    chk({tag, ".rsp_valid_t1"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".err"}, {31'b0, rsp_err}, 32'd1);
    chk({tag, ".noreq"}, {31'b0, mem_req}, 32'd0);
    chk({tag, ".rdata0"}, rsp_rdata, 32'd0);
    tick();
    $display("reject %s addr=%h", tag, addr);
  endtask

  initial begin
    #12;
    chk("reset.ready", {31'b0, req_ready}, 32'd1);
    chk("reset.mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_load("lb_101", 3'b000, 32'h0000_0101, 32'h8899_AABC, 32'hFFFF_FFAA);
    run_load("lbu_100", 3'b100, 32'h0000_0100, 32'h8899_AABC, 32'h0000_00BC);
    run_load("lh_102", 3'b001, 32'h0000_0102, 32'h8899_AABC, 32'hFFFF_8899);
    run_load("lhu_102", 3'b101, 32'h0000_0102, 32'h8899_AABC, 32'h0000_8899);
    run_load("lw_100", 3'b010, 32'h0000_0100, 32'h8899_AABC, 32'h8899_AABC);

    run_store("sh_202", 3'b001, 32'h0000_0202, 32'h0000_1234, 4'b1100, 32'h1234_0000);
    run_store("sb_003", 3'b000, 32'h0000_0003, 32'h0000_005A, 4'b1000, 32'h5A00_0000);
    run_store("sw_010", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    run_reject("illegal_011", 1'b0, 3'b011, 32'h0000_0100);
    run_reject("store_f3_100", 1'b1, 3'b100, 32'h0000_0100);

`ifdef LSU_MISALIGNED_SPLIT_EN
    // lw at 0x103 spans two words.
    mem_gnt = 1'b1;
    issue(1'b0, 3'b010, 32'h0000_0103, 32'b0);
    chk("lw103.addr0", mem_addr, 32'h0000_0100);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    chk("lw103.req1", {31'b0, mem_req}, 32'd1);
    chk("lw103.addr1", mem_addr, 32'h0000_0104);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
    tick();
    mem_rvalid = 1'b0;
    chk("lw103.rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("lw103.rdata", rsp_rdata, 32'h7766_5544);
    chk("lw103.err", {31'b0, rsp_err}, 32'd0);
    tick();
    $display("split load lw103 rdata=77665544");

    mem_gnt = 1'b1;
    issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    chk("swwrap.addr0", mem_addr, 32'hFFFF_FFFC);
    chk("swwrap.be0", {28'b0, mem_be}, 32'h0000_000C);
    chk("swwrap.wd0", mem_wdata, 32'hCCDD_0000);
    tick();
    chk("swwrap.addr1", mem_addr, 32'h0000_0000);
    chk("swwrap.be1", {28'b0, mem_be}, 32'h0000_0003);
    chk("swwrap.wd1", mem_wdata, 32'h0000_AABB);
    tick();
    mem_gnt = 1'b0;
    chk("swwrap.rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("swwrap.err", {31'b0, rsp_err}, 32'd0);
    tick();
    $display("split store swwrap second addr=00000000");
`else
    run_reject("lw_103_misal", 1'b0, 3'b010, 32'h0000_0103);
    run_reject("sw_fffffffe_misal", 1'b1, 3'b010, 32'hFFFF_FFFE);
`endif

    // Grant never arrives: request held exactly four cycles, then error.
    mem_gnt = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0300, 32'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo.req_c%0d", i), {31'b0, mem_req}, 32'd1);
      tick();
    end
    chk("tmo.req_dropped", {31'b0, mem_req}, 32'd0);
    chk("tmo.rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("tmo.err", {31'b0, rsp_err}, 32'd1);
    chk("tmo.rdata", rsp_rdata, 32'd0);
    tick();
    $display("timeout lw addr=00000300 err=1");

    // Grant in the expiry cycle wins.
    issue(1'b0, 3'b010, 32'h0000_0300, 32'b0);
    tick(); tick(); tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    chk("late_gnt.no_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk("late_gnt.rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("late_gnt.err", {31'b0, rsp_err}, 32'd0);
    chk("late_gnt.rdata", rsp_rdata, 32'h1234_5678);
    tick();
    $display("late gnt lw rdata=12345678 err=0");

    // Reset in WAIT0, then a stale rvalid.
    mem_gnt = 1'b1;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'b0);
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wait.ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wait.mem_req", {31'b0, mem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_wait.no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rst_wait.ready2", {31'b0, req_ready}, 32'd1);
    chk("rst_wait.rdata", rsp_rdata, 32'd0);
    tick();
    chk("rst_wait.no_rsp2", {31'b0, rsp_valid}, 32'd0);
    $display("reset during wait0 ignored stale rvalid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
